// File: rtl/det_seq_ctrl.sv
// det_seq_ctrl: loads a word, resets the serial detector, shifts the word into it
//   MSB-first at one bit per (div+1) clocks, and counts z=1 samples.
// Latency: start at T -> LOAD T+1, first det_en T+2+div, done from T+3+WIDTH*(div+1).
// Backpressure: start is ignored while busy; abort returns to IDLE on the next cycle.
// Optional feature macro: FIRST_HIT_EN adds o_first_idx (1-based bit number of first hit).
module det_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int DIV_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [WIDTH-1:0]       i_data_in,
    input  logic [DIV_W-1:0]       i_div,
    input  logic                   i_z_in,
    output logic                   o_w_out,
    output logic                   o_det_en,
    output logic                   o_det_rst,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [CNT_W-1:0]       o_hit_cnt
`ifdef FIRST_HIT_EN
    ,
    output logic [$clog2(WIDTH):0] o_first_idx
`endif
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_data;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [IDX_W-1:0]   r_bit_idx;
    logic               r_samp;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic               w_accept;
    logic               w_tick;

    // A start is only honoured when no run is in flight.
    assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // End of the current bit period.
    assign w_tick   = (r_div_cnt == '0);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort pulls any active run back to IDLE, start wins when idle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = i_abort ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (w_tick && (r_bit_idx == '0)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next = i_abort ? S_IDLE : S_DONE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output decode; w is driven from the latched word so it stays stable per bit.
    always_comb begin
        o_w_out   = 1'b0;
        o_det_en  = 1'b0;
        o_det_rst = 1'b0;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (r_state)
            S_LOAD: begin
                o_det_rst = 1'b1;
                o_busy    = 1'b1;
                o_w_out   = r_data[WIDTH-1];
            end
            S_SHIFT: begin
                o_busy    = 1'b1;
                o_w_out   = r_data[r_bit_idx];
                o_det_en  = w_tick;
            end
            S_DRAIN: begin
                o_busy    = 1'b1;
            end
            S_DONE: begin
                o_done    = 1'b1;
            end
            default: begin
                o_busy    = 1'b0;
            end
        endcase
    end

    // Run parameters latched on an accepted start; bit/divider counters walk the word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data    <= '0;
            r_div     <= '0;
            r_div_cnt <= '0;
            r_bit_idx <= '0;
        end else begin
            if (w_accept) begin
                r_data    <= i_data_in;
                r_div     <= i_div;
                r_bit_idx <= IDX_W'(WIDTH - 1);
            end
            if (r_state == S_LOAD) begin
                r_bit_idx <= IDX_W'(WIDTH - 1);
                r_div_cnt <= r_div;
            end else if (r_state == S_SHIFT) begin
                if (w_tick) begin
                    r_div_cnt <= r_div;
                    r_bit_idx <= r_bit_idx - 1'b1;
                end else begin
                    r_div_cnt <= r_div_cnt - 1'b1;
                end
            end
        end
    end

    // The detector output is registered, so z belongs to the bit enabled one cycle earlier.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_samp <= 1'b0;
        end else begin
            r_samp <= o_det_en;
        end
    end

    // Saturating hit counter; cleared by an accepted start, held across abort.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hit_cnt <= '0;
        end else if (w_accept) begin
            r_hit_cnt <= '0;
        end else if (r_samp && i_z_in && (r_hit_cnt != {CNT_W{1'b1}})) begin
            r_hit_cnt <= r_hit_cnt + 1'b1;
        end
    end

    assign o_hit_cnt = r_hit_cnt;

`ifdef FIRST_HIT_EN
    logic [IDX_W:0] r_smp_num;
    logic [IDX_W:0] r_first_idx;

    // Number of z samples taken so far, and the 1-based index of the first hit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_smp_num   <= '0;
            r_first_idx <= '0;
        end else if (w_accept) begin
            r_smp_num   <= '0;
            r_first_idx <= '0;
        end else if (r_samp) begin
            r_smp_num <= r_smp_num + 1'b1;
            if (i_z_in && (r_first_idx == '0)) begin
                r_first_idx <= r_smp_num + 1'b1;
            end
        end
    end

    assign o_first_idx = r_first_idx;
`else
    // No first-hit tracking in this build.
`endif

endmodule

// File: tb/tb_det_seq_ctrl.sv
// Bench for det_seq_ctrl: a behavioural serial detector (z=1 after 4 equal consecutive w)
// closes the loop; results are compared against a bit-level reference of the run.
// A second instance with a 3-bit counter exercises saturation on the same stimulus.
module tb_det_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int FI_W  = $clog2(WIDTH) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] data;
    logic [7:0]  div;
    logic        z;

    logic        w_out, det_en, det_rst, busy, done;
    logic [4:0]  hit;
    logic        s_w_out, s_det_en, s_det_rst, s_busy, s_done;
    logic [2:0]  s_hit;
`ifdef FIRST_HIT_EN
    logic [FI_W-1:0] first_idx;
    logic [FI_W-1:0] s_first_idx;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    det_seq_ctrl #(.WIDTH(16), .CNT_W(5), .DIV_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_data_in(data), .i_div(div), .i_z_in(z),
        .o_w_out(w_out), .o_det_en(det_en), .o_det_rst(det_rst),
        .o_busy(busy), .o_done(done), .o_hit_cnt(hit)
`ifdef FIRST_HIT_EN
        , .o_first_idx(first_idx)
`endif
    );

    det_seq_ctrl #(.WIDTH(16), .CNT_W(3), .DIV_W(8)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_data_in(data), .i_div(div), .i_z_in(z),
        .o_w_out(s_w_out), .o_det_en(s_det_en), .o_det_rst(s_det_rst),
        .o_busy(s_busy), .o_done(s_done), .o_hit_cnt(s_hit)
`ifdef FIRST_HIT_EN
        , .o_first_idx(s_first_idx)
`endif
    );

    // Serial detector seen by the sequencer: registered z, advances only on det_en.
    logic [2:0] d_cnt;
    logic       d_last;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d_cnt  <= 3'd0;
            d_last <= 1'b0;
            z      <= 1'b0;
        end else if (det_rst) begin
            d_cnt  <= 3'd0;
            z      <= 1'b0;
        end else if (det_en) begin
            d_last <= w_out;
            if (d_cnt != 3'd0 && w_out == d_last) begin
                d_cnt <= (d_cnt == 3'd4) ? 3'd4 : d_cnt + 3'd1;
                z     <= (d_cnt >= 3'd3);
            end else begin
                d_cnt <= 3'd1;
                z     <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: walk the first nbits of the word MSB-first, tracking the equal-bit run.
    function automatic void ref_run(input logic [15:0] d, input int nbits,
                                    output int hits, output int first);
        int run;
        logic b, last;
        hits = 0; first = 0; run = 0; last = 1'b0;
        for (int n = 0; n < nbits; n++) begin
            b = d[WIDTH-1-n];
            run = (n == 0 || b != last) ? 1 : run + 1;
            last = b;
            if (run >= 4) begin
                hits++;
                if (first == 0) first = n + 1;
            end
        end
    endfunction

    task automatic run_seq(input logic [15:0] d, input int dv, input bit mid_start,
                           input bit with_abort);
        int hits, first, per, nde, busy_n, done_k, n;
        ref_run(d, WIDTH, hits, first);
        per = dv + 1;
        nde = 0; busy_n = 0; done_k = 0;
        @(negedge clk);
        data = d; div = 8'(dv); start = 1'b1; abort = with_abort;
        for (int k = 1; k <= 4000 && done_k == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("load_det_rst", det_rst, 1);
                chk("load_det_en", det_en, 0);
                chk("load_w", w_out, d[15]);
                chk("start_clears_hit", hit, 0);
                chk("done_cleared", done, 0);
            end
            if (k >= 2 && k <= 1 + WIDTH * per) begin
                n = (k - 2) / per;
                chk("w_bit", w_out, d[WIDTH-1-n]);
                chk("det_en_phase", det_en, ((k - 1) % per) == 0);
            end
            if (busy) busy_n++;
            if (det_en) nde++;
            if (done) done_k = k;
            // Inputs change after sampling; a latched run must not see these.
            if (k == 1) begin
                start = 1'b0; abort = 1'b0; data = 16'($urandom); div = 8'($urandom);
            end
            if (mid_start && k == 5) start = 1'b1;
            if (mid_start && k == 6) start = 1'b0;
        end
        if (done_k == 0) chk("done_timeout", 0, 1);
        chk("done_cycle", done_k, 3 + WIDTH * per);
        chk("busy_cycles", busy_n, 2 + WIDTH * per);
        chk("det_en_pulses", nde, WIDTH);
        chk("busy_low_in_done", busy, 0);
        chk("hit_cnt", hit, hits);
        chk("hit_cnt_sat", s_hit, (hits > 7) ? 7 : hits);
`ifdef FIRST_HIT_EN
        chk("first_idx", first_idx, first);
`endif
        @(negedge clk);
        chk("done_held", done, 1);
    endtask

    task automatic abort_seq(input logic [15:0] d);
        int hits, first, nde;
        ref_run(d, 5, hits, first);
        nde = 0;
        @(negedge clk);
        data = d; div = 8'd0; start = 1'b1;
        for (int k = 1; k <= 200 && nde < 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (det_en) nde++;
        end
        if (nde < 5) chk("abort_timeout", nde, 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_det_en", det_en, 0);
        @(negedge clk);
        chk("abort_idle_busy", busy, 0);
        chk("abort_partial_hit", hit, hits);
`ifdef FIRST_HIT_EN
        chk("abort_first_idx", first_idx, first);
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_w"}, w_out, 0);
        chk({tag, "_det_en"}, det_en, 0);
        chk({tag, "_det_rst"}, det_rst, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_hit"}, hit, 0);
        chk({tag, "_sat_hit"}, s_hit, 0);
`ifdef FIRST_HIT_EN
        chk({tag, "_first"}, first_idx, 0);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; data = '0; div = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Directed patterns, then start+abort together from DONE, then a mid-run start.
        run_seq(16'hF0F0, 0, 1'b0, 1'b0);
        run_seq(16'hFFFF, 0, 1'b0, 1'b0);
        run_seq(16'hAAAA, 0, 1'b0, 1'b0);
        run_seq(16'h000F, 3, 1'b0, 1'b0);
        run_seq(16'h0FF0, 1, 1'b0, 1'b1);
        run_seq(16'hFFFF, 0, 1'b1, 1'b0);

        // Randomized words and bit periods; biased toward long runs of equal bits.
        for (int r = 0; r < 10; r++) begin
            logic [15:0] rd;
            rd = 16'($urandom);
            if (r % 2 == 1) rd = rd & 16'hFF00 | ((rd[0]) ? 16'h00FF : 16'h0000);
            run_seq(rd, $urandom_range(0, 3), 1'(r % 3 == 0), 1'b0);
        end

        abort_seq(16'hFFFF);
        abort_seq(16'($urandom));
        // Start from IDLE together with abort: start wins.
        run_seq(16'h0F0F, 0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        data = 16'hFFFF; div = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        run_seq(16'hF00F, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
